// File: rtl/id_stage_fwd.sv
// id_stage_fwd: registered RV32 decode stage with priority forwarding and load-use interlock
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   in_valid_i/in_ready_o         upstream handshake for inst_i/inst_addr_i
//   reg{1,2}_raddr_o/_re_o/_rdata_i  regfile read ports (same-cycle data)
//   fwd_we_i/pend_i/waddr_i/wdata_i  forwarding sources, index 0 highest priority
//   flush_i                       discard stage contents
//   out_valid_o/out_ready_i       downstream handshake for the ID/EX register
//   inst_o, inst_addr_o, op1_o, op2_o, reg_we_o, reg_waddr_o  ID/EX register fields
//   stall_cnt_o                   saturating count of load-use stall cycles
module id_stage_fwd #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int NUM_FWD     = 3,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [ADDR_WIDTH-1:0]          inst_addr_i,
    input  logic [DATA_WIDTH-1:0]          inst_i,
    output logic [RADDR_WIDTH-1:0]         reg1_raddr_o,
    output logic [RADDR_WIDTH-1:0]         reg2_raddr_o,
    output logic                           reg1_re_o,
    output logic                           reg2_re_o,
    input  logic [DATA_WIDTH-1:0]          reg1_rdata_i,
    input  logic [DATA_WIDTH-1:0]          reg2_rdata_i,
    input  logic [NUM_FWD-1:0]             fwd_we_i,
    input  logic [NUM_FWD-1:0]             fwd_pend_i,
    input  logic [NUM_FWD*RADDR_WIDTH-1:0] fwd_waddr_i,
    input  logic [NUM_FWD*DATA_WIDTH-1:0]  fwd_wdata_i,
    input  logic                           flush_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [DATA_WIDTH-1:0]          inst_o,
    output logic [ADDR_WIDTH-1:0]          inst_addr_o,
    output logic [DATA_WIDTH-1:0]          op1_o,
    output logic [DATA_WIDTH-1:0]          op2_o,
    output logic                           reg_we_o,
    output logic [RADDR_WIDTH-1:0]         reg_waddr_o,
    output logic [CNT_WIDTH-1:0]           stall_cnt_o
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    // Returns {pending, data}; lowest matching source wins, x0 is always zero and never pending.
    function automatic logic [DATA_WIDTH:0] resolve(
        input logic [RADDR_WIDTH-1:0]         a,
        input logic [DATA_WIDTH-1:0]          rdata,
        input logic [NUM_FWD-1:0]             we,
        input logic [NUM_FWD-1:0]             pend,
        input logic [NUM_FWD*RADDR_WIDTH-1:0] wa,
        input logic [NUM_FWD*DATA_WIDTH-1:0]  wd
    );
        logic [DATA_WIDTH:0] r;
        r = {1'b0, rdata};
        for (int k = NUM_FWD - 1; k >= 0; k--)
            if (we[k] && wa[k*RADDR_WIDTH +: RADDR_WIDTH] == a)
                r = {pend[k], wd[k*DATA_WIDTH +: DATA_WIDTH]};
        return (a == '0) ? '0 : r;
    endfunction

    logic                   is_i, is_r, is_lui, is_auipc, is_s, is_l, known, we_dec, hazard, accept;
    logic [RADDR_WIDTH-1:0] rs1, rs2, rd;
    logic [DATA_WIDTH:0]    f1, f2;
    logic [DATA_WIDTH-1:0]  imm_i, imm_u;

    logic                   valid_q, valid_d, we_q, we_d;
    logic [DATA_WIDTH-1:0]  inst_q, inst_d, op1_q, op1_d, op2_q, op2_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [RADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    assign is_i     = inst_i[6:0] == 7'b0010011;
    assign is_r     = inst_i[6:0] == 7'b0110011;
    assign is_lui   = inst_i[6:0] == 7'b0110111;
    assign is_auipc = inst_i[6:0] == 7'b0010111;
    assign is_s     = inst_i[6:0] == 7'b0100011;
    assign is_l     = inst_i[6:0] == 7'b0000011;
    assign known    = is_i | is_r | is_lui | is_auipc | is_s | is_l;

    assign rs1   = RADDR_WIDTH'(inst_i[19:15]);
    assign rs2   = RADDR_WIDTH'(inst_i[24:20]);
    assign rd    = RADDR_WIDTH'(inst_i[11:7]);
    assign imm_i = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
    assign imm_u = DATA_WIDTH'({inst_i[31:12], 12'b0});

    assign reg1_re_o    = in_valid_i && (is_i || is_r || is_s || is_l);
    assign reg2_re_o    = in_valid_i && (is_r || is_s);
    assign reg1_raddr_o = reg1_re_o ? rs1 : '0;
    assign reg2_raddr_o = reg2_re_o ? rs2 : '0;

    // A disabled port reads address 0, so it resolves to zero and never raises a hazard.
    assign f1     = resolve(reg1_raddr_o, reg1_rdata_i, fwd_we_i, fwd_pend_i, fwd_waddr_i, fwd_wdata_i);
    assign f2     = resolve(reg2_raddr_o, reg2_rdata_i, fwd_we_i, fwd_pend_i, fwd_waddr_i, fwd_wdata_i);
    assign hazard = f1[DATA_WIDTH] | f2[DATA_WIDTH];
    assign we_dec = (is_i || is_r || is_lui || is_auipc || is_l) && rd != '0;

    assign in_ready_o = !rst_i && !flush_i && !hazard && (!valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        addr_d  = addr_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        if (accept) begin
            valid_d = 1'b1;
            inst_d  = known ? inst_i : NOP;
            addr_d  = inst_addr_i;
            op1_d   = is_lui ? imm_u : is_auipc ? DATA_WIDTH'(inst_addr_i) : f1[DATA_WIDTH-1:0];
            op2_d   = is_i ? imm_i : (is_r || is_s) ? f2[DATA_WIDTH-1:0] : is_auipc ? imm_u : '0;
            we_d    = we_dec;
            waddr_d = we_dec ? rd : '0;
        end else if (flush_i || out_ready_i) begin
            valid_d = 1'b0;
            inst_d  = NOP;
            we_d    = 1'b0;
        end
        cnt_d = (in_valid_i && hazard && !flush_i && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            inst_q  <= NOP;
            addr_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            addr_q  <= addr_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_o = valid_q;
    assign inst_o      = inst_q;
    assign inst_addr_o = addr_q;
    assign op1_o       = op1_q;
    assign op2_o       = op2_q;
    assign reg_we_o    = we_q;
    assign reg_waddr_o = waddr_q;
    assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_stage_fwd.sv
// tb_id_stage_fwd: table-driven and scoreboard checks of the id_stage_fwd decode stage
module tb_id_stage_fwd;
    logic        clk = 1'b0, rst, in_valid, in_ready, re1, re2, flush, out_valid, out_ready, we_o;
    logic [31:0] pc, inst, rdata1, rdata2, inst_o, pc_o, op1, op2;
    logic [4:0]  raddr1, raddr2, wa_o;
    logic [2:0]  fwd_we, fwd_pend;
    logic [14:0] fwd_wa;
    logic [95:0] fwd_wd;
    logic [1:0]  stall;

    typedef struct {
        logic [31:0] inst, pc, rd1, rd2;
        logic [2:0]  we, pend;
        logic [14:0] wa;
        logic [95:0] wd;
        logic        rdy, re1, re2;
        logic [31:0] xinst, xop1, xop2;
        logic        xwe;
        logic [4:0]  xwa;
    } vec_t;
    typedef struct {
        logic [31:0] inst, pc, op1, op2;
        logic        we;
        logic [4:0]  wa;
    } exp_t;

    vec_t vecs[10];
    exp_t sbq[$];
    int   errors = 0, checks = 0;

    id_stage_fwd #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .NUM_FWD(3), .CNT_WIDTH(2)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .inst_addr_i(pc), .inst_i(inst), .reg1_raddr_o(raddr1), .reg2_raddr_o(raddr2),
        .reg1_re_o(re1), .reg2_re_o(re2), .reg1_rdata_i(rdata1), .reg2_rdata_i(rdata2),
        .fwd_we_i(fwd_we), .fwd_pend_i(fwd_pend), .fwd_waddr_i(fwd_wa), .fwd_wdata_i(fwd_wd),
        .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready), .inst_o(inst_o),
        .inst_addr_o(pc_o), .op1_o(op1), .op2_o(op2), .reg_we_o(we_o), .reg_waddr_o(wa_o),
        .stall_cnt_o(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0; flush = 1'b0; inst = 32'h0; pc = 32'h0; rdata1 = 32'h0; rdata2 = 32'h0;
        fwd_we = 3'b0; fwd_pend = 3'b0; fwd_wa = 15'h0; fwd_wd = 96'h0;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1; flush = 1'b0; inst = v.inst; pc = v.pc; rdata1 = v.rd1; rdata2 = v.rd2;
        fwd_we = v.we; fwd_pend = v.pend; fwd_wa = v.wa; fwd_wd = v.wd;
    endtask

    task automatic push(input vec_t v);
        sbq.push_back('{v.xinst, v.pc, v.xop1, v.xop2, v.xwe, v.xwa});
    endtask

    task automatic pop_check(input string t);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", t);
        end else begin
            e = sbq.pop_front();
            chk({t, ".valid"}, 32'(out_valid), 32'd1);
            chk({t, ".inst"}, inst_o, e.inst);
            chk({t, ".pc"}, pc_o, e.pc);
            chk({t, ".op1"}, op1, e.op1);
            chk({t, ".op2"}, op2, e.op2);
            chk({t, ".we"}, 32'(we_o), 32'(e.we));
            chk({t, ".waddr"}, 32'(wa_o), 32'(e.wa));
        end
    endtask

    task automatic reset_pulse;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h00500093, 32'h100, 32'h1234, 32'h0, 3'b000, 3'b000, 15'h0, 96'h0,
                    1'b1, 1'b1, 1'b0, 32'h00500093, 32'h0, 32'h5, 1'b1, 5'd1};
        vecs[1] = '{32'h002081B3, 32'h104, 32'h11, 32'h7, 3'b101, 3'b000, {5'd1, 5'd0, 5'd1},
                    {32'hBB, 32'h0, 32'hAA}, 1'b1, 1'b1, 1'b1, 32'h002081B3, 32'hAA, 32'h7, 1'b1, 5'd3};
        vecs[2] = '{32'h12345237, 32'h108, 32'h9, 32'h9, 3'b000, 3'b000, 15'h0, 96'h0,
                    1'b1, 1'b0, 1'b0, 32'h12345237, 32'h12345000, 32'h0, 1'b1, 5'd4};
        vecs[3] = '{32'h00001297, 32'h200, 32'h9, 32'h9, 3'b000, 3'b000, 15'h0, 96'h0,
                    1'b1, 1'b0, 1'b0, 32'h00001297, 32'h200, 32'h1000, 1'b1, 5'd5};
        vecs[4] = '{32'h0020A423, 32'h204, 32'h1000, 32'hCAFE, 3'b010, 3'b000, {5'd0, 5'd2, 5'd0},
                    {32'h0, 32'h55, 32'h0}, 1'b1, 1'b1, 1'b1, 32'h0020A423, 32'h1000, 32'h55, 1'b0, 5'd0};
        vecs[5] = '{32'h0042A303, 32'h208, 32'h3000, 32'h0, 3'b100, 3'b000, {5'd5, 5'd0, 5'd0},
                    {32'h77, 32'h0, 32'h0}, 1'b1, 1'b1, 1'b0, 32'h0042A303, 32'h77, 32'h0, 1'b1, 5'd6};
        vecs[6] = '{32'hFFFFFFFF, 32'h20C, 32'h1, 32'h2, 3'b000, 3'b000, 15'h0, 96'h0,
                    1'b1, 1'b0, 1'b0, 32'h00000013, 32'h0, 32'h0, 1'b0, 5'd0};
        vecs[7] = '{32'h00100013, 32'h210, 32'h0, 32'h0, 3'b001, 3'b001, 15'h0, 96'h1,
                    1'b1, 1'b1, 1'b0, 32'h00100013, 32'h0, 32'h1, 1'b0, 5'd0};
        vecs[8] = '{32'hFFF08393, 32'h214, 32'h0, 32'h0, 3'b011, 3'b010, {5'd0, 5'd1, 5'd1},
                    {32'h0, 32'h20, 32'h10}, 1'b1, 1'b1, 1'b0, 32'hFFF08393, 32'h10, 32'hFFFFFFFF, 1'b1, 5'd7};
        vecs[9] = '{32'h00000433, 32'h218, 32'h5, 32'h6, 3'b000, 3'b000, 15'h0, 96'h0,
                    1'b1, 1'b1, 1'b1, 32'h00000433, 32'h0, 32'h0, 1'b1, 5'd8};

        idle();
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.inst", inst_o, 32'h00000013);
        chk("rst.pc", pc_o, 32'h0);
        chk("rst.op1", op1, 32'h0);
        chk("rst.op2", op2, 32'h0);
        chk("rst.we", 32'(we_o), 32'd0);
        chk("rst.waddr", 32'(wa_o), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d.ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d.re1", i), 32'(re1), 32'(vecs[i].re1));
            chk($sformatf("v%0d.re2", i), 32'(re2), 32'(vecs[i].re2));
            chk($sformatf("v%0d.raddr1", i), 32'(raddr1), vecs[i].re1 ? 32'(vecs[i].inst[19:15]) : 32'h0);
            chk($sformatf("v%0d.raddr2", i), 32'(raddr2), vecs[i].re2 ? 32'(vecs[i].inst[24:20]) : 32'h0);
            if (vecs[i].rdy) push(vecs[i]);
            step();
            pop_check($sformatf("v%0d", i));
        end
        idle();
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);
        chk("drain.inst", inst_o, 32'h00000013);
        chk("drain.stall", 32'(stall), 32'd0);

        // Load-use interlock, then release, then saturation of the 2-bit counter.
        reset_pulse();
        in_valid = 1'b1; inst = 32'h00028333; pc = 32'h300; rdata1 = 32'h1; rdata2 = 32'h2;
        fwd_we = 3'b001; fwd_pend = 3'b001; fwd_wa = 15'd5; fwd_wd = 96'h99;
        #1;
        chk("lu.ready0", 32'(in_ready), 32'd0);
        step();
        chk("lu.stall1", 32'(stall), 32'd1);
        chk("lu.valid1", 32'(out_valid), 32'd0);
        step();
        chk("lu.stall2", 32'(stall), 32'd2);
        fwd_pend = 3'b000;
        #1;
        chk("lu.ready1", 32'(in_ready), 32'd1);
        sbq.push_back('{32'h00028333, 32'h300, 32'h99, 32'h0, 1'b1, 5'd6});
        step();
        pop_check("lu");
        chk("lu.stall_hold", 32'(stall), 32'd2);
        fwd_pend = 3'b001;
        for (int i = 0; i < 3; i++) step();
        chk("lu.stall_sat", 32'(stall), 32'd3);

        // Backpressure hold, then release with back-to-back accept.
        reset_pulse();
        drive(vecs[0]);
        push(vecs[0]);
        step();
        out_ready = 1'b0;
        drive(vecs[2]);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("hold%0d.ready", i), 32'(in_ready), 32'd0);
            step();
            chk($sformatf("hold%0d.inst", i), inst_o, 32'h00500093);
            chk($sformatf("hold%0d.op2", i), op2, 32'h5);
            chk($sformatf("hold%0d.valid", i), 32'(out_valid), 32'd1);
        end
        pop_check("hold");
        out_ready = 1'b1;
        #1;
        chk("release.ready", 32'(in_ready), 32'd1);
        push(vecs[2]);
        step();
        pop_check("release");

        // Flush with valid held output and a pending hazard.
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h00028333; pc = 32'h400;
        fwd_we = 3'b001; fwd_pend = 3'b001; fwd_wa = 15'd5; fwd_wd = 96'h0; flush = 1'b1;
        #1;
        chk("flush.ready", 32'(in_ready), 32'd0);
        step();
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.inst", inst_o, 32'h00000013);
        chk("flush.we", 32'(we_o), 32'd0);
        chk("flush.stall", 32'(stall), 32'd0);
        flush = 1'b0;
        step();
        chk("postflush.stall", 32'(stall), 32'd1);

        // Reset while holding a valid output and stalling.
        reset_pulse();
        out_ready = 1'b1;
        drive(vecs[1]);
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; inst = 32'h00028333; fwd_we = 3'b001; fwd_pend = 3'b001; fwd_wa = 15'd5;
        step();
        chk("midrst.pre_valid", 32'(out_valid), 32'd1);
        chk("midrst.pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst.valid", 32'(out_valid), 32'd0);
        chk("midrst.inst", inst_o, 32'h00000013);
        chk("midrst.op1", op1, 32'h0);
        chk("midrst.stall", 32'(stall), 32'd0);
        rst = 1'b0;
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
